// File: rtl/xorframe_pkg.sv
// Shared types and sizing helpers for the xorframe transmit framer.
package xorframe_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HDR     = 2'd1,
    DATA    = 2'd2
  } state_e;

  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_MAX_LEN = 16;

  // Counters must hold the value MAX_LEN itself (the header length).
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int addr_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/xorframe_buf.sv
// Single-packet payload store: one synchronous write port, one asynchronous read port.
module xorframe_buf
  import xorframe_pkg::*;
#(
  parameter int dwidth  = DEF_DWIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int AW      = addr_width(MAX_LEN)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [dwidth-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [dwidth-1:0] rd_data_o
);

  logic [dwidth-1:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/xorframe_gen.sv
// Framer: collects one packet, then emits [N][b0..bN-1] to the executor input fifo.
// Optional XORFRAME_CHECK_EN builds a running-XOR of the payload for result checking.
module xorframe_gen
  import xorframe_pkg::*;
#(
  parameter int dwidth  = DEF_DWIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [dwidth-1:0] in_data,
  input  logic              in_last,
  input  logic              ofifo_not_full,
  output logic              ofifo_push,
  output logic [dwidth-1:0] ofifo_data,
  output logic              busy,
  output logic              trunc_err,
  output logic              exp_valid,
  output logic [dwidth-1:0] exp_xor
);

  localparam int CW = cnt_width(MAX_LEN);
  localparam int AW = addr_width(MAX_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_e            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     len_q, len_d;
  logic              trunc_q, trunc_d;
  logic              buf_we;
  logic [dwidth-1:0] buf_rd;
  logic              final_push;

  xorframe_buf #(
    .dwidth  (dwidth),
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_addr_i (wr_cnt_q[AW-1:0]),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (buf_rd)
  );

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    trunc_d    = 1'b0;
    buf_we     = 1'b0;
    in_ready   = 1'b0;
    ofifo_push = 1'b0;
    ofifo_data = '0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          if (in_last || (wr_cnt_q == LAST_IDX)) begin
            len_d    = wr_cnt_q + ONE;
            wr_cnt_d = '0;
            state_d  = HDR;
            trunc_d  = !in_last;
          end else begin
            wr_cnt_d = wr_cnt_q + ONE;
          end
        end
      end
      HDR: begin
        ofifo_data = dwidth'(len_q);
        if (ofifo_not_full) begin
          ofifo_push = 1'b1;
          rd_ptr_d   = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        ofifo_data = buf_rd;
        if (ofifo_not_full) begin
          ofifo_push = 1'b1;
          rd_ptr_d   = rd_ptr_q + ONE;
          if (rd_ptr_q == len_q - ONE) begin
            state_d = COLLECT;
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      trunc_q  <= trunc_d;
    end
  end

  assign final_push = (state_q == DATA) && ofifo_not_full && (rd_ptr_q == len_q - ONE);
  assign busy       = (state_q != COLLECT) || (wr_cnt_q != '0);
  assign trunc_err  = trunc_q;

`ifdef XORFRAME_CHECK_EN
  logic [dwidth-1:0] xor_q, xor_d;

  // First byte of a packet restarts the accumulator instead of folding into the old value.
  always_comb begin
    xor_d = xor_q;
    if ((state_q == COLLECT) && in_valid) begin
      xor_d = (wr_cnt_q == '0) ? in_data : (xor_q ^ in_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end

  assign exp_valid = final_push;
  assign exp_xor   = final_push ? xor_q : '0;
`else
  assign exp_valid = 1'b0;
  assign exp_xor   = '0;
`endif

endmodule
